// File: rtl/reg_scoreboard_pkg.sv
// reg_scoreboard_pkg: shared types and sizing for the LC-3b decode-stage register scoreboard.
package reg_scoreboard_pkg;
    localparam int NUM_REGS = 8;
    localparam int CNT_W    = 2;
    localparam int STALL_W  = 16;
    localparam int REG_W    = $clog2(NUM_REGS);

    localparam logic [CNT_W-1:0] SB_CNT_MAX = '1;

    typedef logic [REG_W-1:0] lc3b_reg;

    typedef struct packed {
        logic    valid;
        lc3b_reg sr1;
        logic    sr1_use;
        lc3b_reg sr2;
        logic    sr2_use;
        lc3b_reg dest;
        logic    dest_use;
    } sb_dec_req;
endpackage

// File: rtl/reg_scoreboard_if.sv
// reg_scoreboard_if: decode request, writeback/kill release and scoreboard status bundle.
interface reg_scoreboard_if;
    import reg_scoreboard_pkg::*;

    sb_dec_req            dec;
    logic                 freeze;
    logic                 wb_load;
    lc3b_reg              wb_dest;
    logic                 kill_valid;
    lc3b_reg              kill_dest;
    logic                 stall;
    logic                 issue;
    logic [NUM_REGS-1:0]  busy;
    logic [STALL_W-1:0]   stall_count;
    logic                 sb_error;

    modport master (
        output dec, freeze, wb_load, wb_dest, kill_valid, kill_dest,
        input  stall, issue, busy, stall_count, sb_error
    );

    modport slave (
        input  dec, freeze, wb_load, wb_dest, kill_valid, kill_dest,
        output stall, issue, busy, stall_count, sb_error
    );
endinterface

// File: rtl/reg_scoreboard_sb_counter.sv
// sb_counter: pending-write counter for one register; net delta per cycle, clamped, with error pulse.
module sb_counter #(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             dec_w,
    input  logic             dec_k,
    output logic [CNT_W-1:0] count,
    output logic [CNT_W-1:0] count_next,
    output logic             err
);
    logic [CNT_W:0] up, dn, diff;
    logic           under, over;

    always_comb begin
        up         = {1'b0, count} + {{CNT_W{1'b0}}, inc};
        dn         = {{CNT_W{1'b0}}, dec_w} + {{CNT_W{1'b0}}, dec_k};
        diff       = up - dn;
        under      = up < dn;
        over       = !under && diff[CNT_W];
        count_next = under ? '0 : over ? '1 : diff[CNT_W-1:0];
        err        = under | over;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) count <= '0;
        else        count <= count_next;
    end
endmodule

// File: rtl/reg_scoreboard.sv
// reg_scoreboard: decode-stage hazard scheduler tracking in-flight register writes.
// Hazards use registered state only, so a writeback frees its register one cycle later.
module reg_scoreboard
    import reg_scoreboard_pkg::*;
(
    input logic             clk,
    input logic             rst_n,
    reg_scoreboard_if.slave sb
);
    sb_dec_req           d;
    logic [CNT_W-1:0]    count      [NUM_REGS];
    logic [CNT_W-1:0]    count_next [NUM_REGS];
    logic [NUM_REGS-1:0] inc, dec_w, dec_k, err, busy_next;
    logic [NUM_REGS-1:0] busy_q;
    logic [STALL_W-1:0]  stall_cnt;
    logic                err_q, hz1, hz2, hzf, stall, issue;

    assign d     = sb.dec;
    assign hz1   = d.sr1_use & busy_q[d.sr1];
    assign hz2   = d.sr2_use & busy_q[d.sr2];
    assign hzf   = d.dest_use & (count[d.dest] == SB_CNT_MAX);
    assign stall = d.valid & (hz1 | hz2 | hzf);
    assign issue = d.valid & ~stall & ~sb.freeze;

    genvar i;
    generate
        for (i = 0; i < NUM_REGS; i++) begin : g_reg
            assign inc[i]       = issue & d.dest_use & (d.dest == lc3b_reg'(i));
            assign dec_w[i]     = sb.wb_load & (sb.wb_dest == lc3b_reg'(i));
            assign dec_k[i]     = sb.kill_valid & (sb.kill_dest == lc3b_reg'(i));
            assign busy_next[i] = count_next[i] != '0;
            sb_counter #(.CNT_W(CNT_W)) u_cnt (
                .clk        (clk),
                .rst_n      (rst_n),
                .inc        (inc[i]),
                .dec_w      (dec_w[i]),
                .dec_k      (dec_k[i]),
                .count      (count[i]),
                .count_next (count_next[i]),
                .err        (err[i])
            );
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q    <= '0;
            stall_cnt <= '0;
            err_q     <= 1'b0;
        end else begin
            busy_q <= busy_next;
            if (stall && !sb.freeze && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
            if (|err) err_q <= 1'b1;
        end
    end

    assign sb.stall       = stall;
    assign sb.issue       = issue;
    assign sb.busy        = busy_q;
    assign sb.stall_count = stall_cnt;
    assign sb.sb_error    = err_q;
endmodule
